// File: rtl/noise_sched.sv
// rtl/noise_sched.sv - round-robin arbiter sharing one XNOR noise LFSR between requesters
module noise_sched #(
    parameter int             N    = 14,
    parameter int             M    = 12,
    parameter int             NREQ = 4,
    parameter logic [N-1:0]   TAPS = 14'h3802,
    parameter logic [N-1:0]   SEED = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [M-1:0]    dout,
    output logic            dout_vld,
    input  logic            free_run,
    input  logic            seed_load,
    input  logic [N-1:0]    seed,
    output logic            busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [M-1:0]    dout_q, dout_d;
    logic            vld_q, vld_d;

    logic [N-1:0]    shift_step;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   ptr_nxt;
    int              j;

    // All-ones is the XNOR lock-up state; it can only be avoided, never escaped.
    assign shift_step = {shift_q[N-2:0], ~^(shift_q & TAPS)};

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = PW'(j);
            end
        end
        ptr_nxt = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PW'(1);
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        if (seed_load) begin
            // Outputs are registered, so a grant already showing completes untouched.
            shift_d = (seed == {N{1'b1}}) ? SEED : seed;
            state_d = ST_FLUSH;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    shift_d = shift_step;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (win_found) begin
                        shift_d = shift_step;
                        state_d = ST_GRANT;
                        gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        dout_d  = shift_step[N-1:N-M];
                        vld_d   = 1'b1;
                        ptr_d   = ptr_nxt;
                    end else if (free_run) begin
                        shift_d = shift_step;
                    end
                end
                ST_GRANT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            shift_q <= SEED;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt      = gnt_q;
    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign busy     = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_noise_sched.sv
// tb/tb_noise_sched.sv - directed self-checking bench for noise_sched
module tb_noise_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [11:0] dout;
    logic        dout_vld;
    logic        free_run;
    logic        seed_load;
    logic [13:0] seed;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    noise_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .free_run  (free_run),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] model_n(input logic [13:0] s0, input int n);
        logic [13:0] s;
        s = s0;
        for (int k = 0; k < n; k++) begin
            s = {s[12:0], ~(s[13] ^ s[12] ^ s[11] ^ s[1])};
        end
        return s;
    endfunction

    task automatic wait_gnt(input int budget, output int cyc);
        cyc = 0;
        while (gnt == 4'b0 && cyc < budget) begin
            tick;
            cyc++;
        end
        check("wait_gnt_timeout", 32'(gnt != 4'b0), 32'd1);
    endtask

    // Sampling point is just after the edge that entered FLUSH.
    task automatic flush_then_grant(input string tag, input logic [3:0] exp_gnt,
                                    input logic [13:0] s0);
        int   cyc;
        logic [13:0] m;
        for (int k = 0; k < 14; k++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nognt"}, 32'(gnt), 32'd0);
            tick;
        end
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        wait_gnt(4, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd1);
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_vld"}, 32'(dout_vld), 32'd1);
        m = model_n(s0, 15);
        check({tag, "_dout"}, 32'(dout), 32'(m[13:2]));
    endtask

    logic [3:0]  gseq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001};
    logic [13:0] m;
    logic [11:0] last_dout;
    logic        any_out;
    int          g;

    initial begin
        rst = 1'b1; req = '0; free_run = 1'b0; seed_load = 1'b0; seed = '0;
        tick;
        tick;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_vld", 32'(dout_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Reset release with all requesters asserted: flush, then rotation.
        rst = 1'b0; req = 4'b1111;
        flush_then_grant("boot", 4'b0001, 14'h0000);
        g = 1;
        last_dout = dout;
        for (int k = 1; k < 9; k++) begin
            tick;
            check("rr_gnt", 32'(gnt), 32'(gseq[k]));
            check("rr_vld", 32'(dout_vld), 32'(gseq[k] != 4'b0));
            if (gseq[k] != 4'b0) begin
                g++;
                m = model_n(14'h0000, 14 + g);
                check("rr_dout", 32'(dout), 32'(m[13:2]));
                last_dout = dout;
            end else begin
                check("rr_dout_hold", 32'(dout), 32'(last_dout));
            end
        end

        // State S19 after the last grant; five free-run steps then one grant step.
        req = 4'b0000;
        tick;
        free_run = 1'b1;
        for (int k = 0; k < 5; k++) tick;
        free_run = 1'b0; req = 4'b0100;
        tick;
        check("fr5_gnt", 32'(gnt), 32'h4);
        m = model_n(14'h0000, 25);
        check("fr5_dout", 32'(dout), 32'(m[13:2]));

        // Single requester held high: a grant every second cycle, consecutive states.
        for (int k = 26; k <= 27; k++) begin
            tick;
            check("single_gap", 32'(gnt), 32'd0);
            tick;
            check("single_gnt", 32'(gnt), 32'h4);
            m = model_n(14'h0000, k);
            check("single_dout", 32'(dout), 32'(m[13:2]));
        end

        // Full free-run period brings the register back to the same state.
        req = 4'b0000;
        tick;
        free_run = 1'b1;
        any_out = 1'b0;
        for (int k = 0; k < 16383; k++) begin
            tick;
            any_out = any_out | (gnt != 4'b0) | dout_vld;
        end
        check("period_quiet", 32'(any_out), 32'd0);
        free_run = 1'b0; req = 4'b0100;
        tick;
        check("period_gnt", 32'(gnt), 32'h4);
        m = model_n(14'h0000, 28);
        check("period_dout", 32'(dout), 32'(m[13:2]));

        // Illegal all-ones seed is replaced by SEED; seed_load beats a pending request.
        req = 4'b0000;
        tick;
        seed_load = 1'b1; seed = 14'h3FFF; req = 4'b0001;
        tick;
        seed_load = 1'b0;
        flush_then_grant("seed_ones", 4'b0001, 14'h0000);

        // seed_load during a visible grant: that pulse stands, next one uses new seed.
        check("sg_pulse_gnt", 32'(gnt), 32'h1);
        check("sg_pulse_vld", 32'(dout_vld), 32'd1);
        seed_load = 1'b1; seed = 14'h1234; req = 4'b0010;
        tick;
        seed_load = 1'b0;
        flush_then_grant("seed_gnt", 4'b0010, 14'h1234);

        // ptr now 2; grant bit 2 then reset in the GRANT cycle.
        req = 4'b0000;
        tick;
        req = 4'b1111;
        tick;
        check("pre_rst_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        tick;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_vld", 32'(dout_vld), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        flush_then_grant("post_rst", 4'b0001, 14'h0000);

        // rst and seed_load together: reset wins, SEED is used.
        rst = 1'b1; seed_load = 1'b1; seed = 14'h1234;
        tick;
        rst = 1'b0; seed_load = 1'b0;
        flush_then_grant("rst_vs_seed", 4'b0001, 14'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
